grasshopper_decoder: RTL and testbench



---
 rtl/grasshopper_decoder.sv | 164 ++++++++++++++++
 tb/tb_grasshopper_decoder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grasshopper_decoder.sv
// Kuznyechik (GOST R 34.12-2015) iterative block decryptor.
// One ciphertext block in, one plaintext block out. L^-1 runs as sixteen
// single-cycle R^-1 steps per round, S^-1 plus the key add takes one more
// cycle, and round keys are read combinationally from a shared key store.
`timescale 1ns/1ps

module grasshopper_decoder #(
    parameter int BLOCK_W = 128,
    parameter int ROUNDS  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] data_i,
    output logic [3:0]         key_idx_o,
    input  logic [BLOCK_W-1:0] key_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] data_o,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, LIN, SUB, DONE} state_t;

    // Coefficients of the linear form l, byte for a15 in the top byte.
    localparam logic [127:0] L_COEF = 128'h94_20_85_10_c2_c0_01_fb_01_c0_c2_10_85_20_94_01;

    // Forward pi substitution, entry 0 in the most significant byte.
    localparam logic [2047:0] PI_FWD = {
        128'hfceedd11cf6e3116fbc4fada23c5044d,
        128'he977f0db932e99ba1736f1bb14cd5fc1,
        128'hf918655ae25cef21811c3c428b018e4f,
        128'h058402aee36a8fa0060bed987fd4d31f,
        128'heb342c51eac848abf22a68a2fd3acecc,
        128'hb5700e56080c7612bf7213479cb75d87,
        128'h15a19629107b9ac7f391786f9d9eb2b1,
        128'h3275193dff358a7e6d54c680c3bd0d57,
        128'hdff524a93ea843c9d779d6f67c22b903,
        128'he00fecde7a94b0bcdce828504e330a4a,
        128'ha79760731e0062441ab83882649f2641,
        128'had454692275e552f8ca3a57d69d5953b,
        128'h0758b34086ac1df730376be488d9e789,
        128'he11b83494c3ff8fe8d53aa90cad88561,
        128'h207167a42d2b095bcb9b25d0bee56c52,
        128'h59a674d2e6f4b4c0d166afc2394b63b6
    };

    // Build the inverse table at elaboration: inv[pi[i]] = i, entry v at bits v*8.
    function automatic logic [2047:0] invert_pi(input logic [2047:0] fwd);
        logic [2047:0] inv;
        inv = '0;
        for (int i = 0; i < 256; i++) begin
            inv[int'(fwd[(255 - i) * 8 +: 8]) * 8 +: 8] = 8'(i);
        end
        return inv;
    endfunction

    localparam logic [2047:0] PI_INV = invert_pi(PI_FWD);

    // GF(2^8) multiply, reduction polynomial x^8+x^7+x^6+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'hc3 : 8'h00);
        end
        return acc;
    endfunction

    // Linear form l over the 16 bytes of a.
    function automatic logic [7:0] lin_l(input logic [127:0] a);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ gf_mul(a[i * 8 +: 8], L_COEF[i * 8 +: 8]);
        end
        return acc;
    endfunction

    // One inverse linear step: rotate a15 to the bottom, then append l of it.
    function automatic logic [127:0] inv_r(input logic [127:0] v);
        return {v[119:0], lin_l({v[119:0], v[127:120]})};
    endfunction

    // Inverse substitution on each byte independently.
    function automatic logic [127:0] inv_s(input logic [127:0] v);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            r[b * 8 +: 8] = PI_INV[int'(v[b * 8 +: 8]) * 8 +: 8];
        end
        return r;
    endfunction

    state_t             state;
    logic [BLOCK_W-1:0] x;
    logic [3:0]         round;
    logic [3:0]         cnt;

    // The key store is read in the same cycle, so the index follows the state directly.
    assign key_idx_o = (state == IDLE) ? 4'(ROUNDS) : round;
    assign data_o    = x;

    // Control FSM, datapath state register and registered handshake flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // sees the values from before this edge, independent of statement order.
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            round     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x        <= data_i ^ key_i;
                        round    <= 4'(ROUNDS - 1);
                        cnt      <= '0;
                        state    <= LIN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                LIN: begin
                    x <= inv_r(x);
                    if (cnt == 4'd15) begin
                        cnt   <= '0;
                        state <= SUB;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SUB: begin
                    x <= inv_s(x) ^ key_i;
                    if (round == 4'd1) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        round <= round - 4'd1;
                        state <= LIN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grasshopper_decoder.sv
// Self-checking bench for grasshopper_decoder. Expected plaintexts come from
// a forward-direction Kuznyechik model: random plaintexts are encrypted in
// the bench and the decoder must recover them.
`timescale 1ns/1ps

module tb_grasshopper_decoder;

    localparam int TIMEOUT = 400;
    localparam int LAT     = 153;
    localparam logic [255:0] MASTER_KEY =
        256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    localparam logic [127:0] STD_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] STD_PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam int L_COEF [16] = '{148, 32, 133, 16, 194, 192, 1, 251,
                                   1, 192, 194, 16, 133, 32, 148, 1};
    localparam logic [2047:0] PI_TAB = {
        128'hfceedd11cf6e3116fbc4fada23c5044d,
        128'he977f0db932e99ba1736f1bb14cd5fc1,
        128'hf918655ae25cef21811c3c428b018e4f,
        128'h058402aee36a8fa0060bed987fd4d31f,
        128'heb342c51eac848abf22a68a2fd3acecc,
        128'hb5700e56080c7612bf7213479cb75d87,
        128'h15a19629107b9ac7f391786f9d9eb2b1,
        128'h3275193dff358a7e6d54c680c3bd0d57,
        128'hdff524a93ea843c9d779d6f67c22b903,
        128'he00fecde7a94b0bcdce828504e330a4a,
        128'ha79760731e0062441ab83882649f2641,
        128'had454692275e552f8ca3a57d69d5953b,
        128'h0758b34086ac1df730376be488d9e789,
        128'he11b83494c3ff8fe8d53aa90cad88561,
        128'h207167a42d2b095bcb9b25d0bee56c52,
        128'h59a674d2e6f4b4c0d166afc2394b63b6
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] data_i, key_i, data_o;
    logic [3:0]   key_idx_o;

    logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [127:0] data_i2, key_i2, data_o2;
    logic [3:0]   key_idx2;

    logic [127:0] keys [1:10];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grasshopper_decoder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_i(data_i), .key_idx_o(key_idx_o), .key_i(key_i),
        .out_valid(out_valid), .out_ready(out_ready), .data_o(data_o), .busy(busy)
    );

    // Two-round instance over an all-zero key store: output is S^-1(L^-1(input)).
    grasshopper_decoder #(.ROUNDS(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .data_i(data_i2), .key_idx_o(key_idx2), .key_i(key_i2),
        .out_valid(out_valid2), .out_ready(out_ready2), .data_o(data_o2), .busy(busy2)
    );

    assign key_i2 = '0;

    // Key store: combinational read by index.
    always_comb begin
        key_i = '0;
        if (key_idx_o >= 4'd1 && key_idx_o <= 4'd10) key_i = keys[key_idx_o];
    end

    // ---------------- reference model (forward cipher) ----------------
    function automatic logic [7:0] mdl_gmul(input logic [7:0] a, input logic [7:0] b);
        int xa, yb, r;
        xa = int'(a); yb = int'(b); r = 0;
        while (yb != 0) begin
            if ((yb & 1) != 0) r = r ^ xa;
            xa = xa << 1;
            if ((xa & 'h100) != 0) xa = xa ^ 'h1c3;
            yb = yb >> 1;
        end
        return 8'(r);
    endfunction

    function automatic logic [7:0] mdl_pi(input logic [7:0] v);
        return PI_TAB[(255 - int'(v)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] mdl_l(input logic [127:0] a);
        logic [7:0] acc;
        acc = '0;
        for (int k = 0; k < 16; k++) acc = acc ^ mdl_gmul(a[(15 - k) * 8 +: 8], 8'(L_COEF[k]));
        return acc;
    endfunction

    function automatic logic [127:0] mdl_lt(input logic [127:0] a);
        logic [127:0] v;
        v = a;
        for (int k = 0; k < 16; k++) v = {mdl_l(v), v[127:8]};
        return v;
    endfunction

    function automatic logic [127:0] mdl_s(input logic [127:0] a);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[k * 8 +: 8] = mdl_pi(a[k * 8 +: 8]);
        return v;
    endfunction

    function automatic logic [127:0] mdl_sinv(input logic [127:0] a);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 256; j++)
                if (mdl_pi(8'(j)) == a[k * 8 +: 8]) v[k * 8 +: 8] = 8'(j);
        return v;
    endfunction

    function automatic logic [127:0] mdl_encrypt(input logic [127:0] p);
        logic [127:0] v;
        v = p;
        for (int i = 1; i <= 9; i++) v = mdl_lt(mdl_s(v ^ keys[i]));
        return v ^ keys[10];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic expand_keys(input logic [255:0] mk);
        logic [127:0] a1, a0, t;
        a1 = mk[255:128];
        a0 = mk[127:0];
        keys[1] = a1;
        keys[2] = a0;
        for (int i = 1; i <= 4; i++) begin
            for (int j = 1; j <= 8; j++) begin
                t  = mdl_lt(mdl_s(a1 ^ mdl_lt(128'(8 * (i - 1) + j)))) ^ a0;
                a0 = a1;
                a1 = t;
            end
            keys[2 * i + 1] = a1;
            keys[2 * i + 2] = a0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [127:0] d);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        data_i   = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        data_i   = rand128();
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (out_valid !== 1'b1 && lat < TIMEOUT);
        if (out_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL wait_out_timeout: out_valid=%b after %0d cycles", out_valid, lat);
            lat = -1;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        total++; if (data_o !== '0)      begin bad++; $display("FAIL reset_data_o: got %h required 0", data_o); end
        total++; if (key_idx_o !== 4'd10) begin bad++; $display("FAIL reset_key_idx: got %0d required 10", key_idx_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_standard();
        int lat;
        send(STD_CT);
        wait_out(lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL std_latency: got %0d required %0d", lat, LAT); end
        total++; if (data_o !== STD_PT) begin bad++; $display("FAIL std_data: got %h required %h", data_o, STD_PT); end
        release_out();
    endtask

    task automatic test_random();
        int lat;
        logic [127:0] p;
        for (int n = 0; n < 4; n++) begin
            p = rand128();
            send(mdl_encrypt(p));
            wait_out(lat);
            total++; if (lat != LAT) begin bad++; $display("FAIL rand_latency[%0d]: got %0d required %0d", n, lat, LAT); end
            total++; if (data_o !== p) begin bad++; $display("FAIL rand_data[%0d]: got %h required %h", n, data_o, p); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic ok;
        send(STD_CT);
        wait_out(lat);
        ok = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || data_o !== STD_PT || in_ready !== 1'b0 || busy !== 1'b1) begin
                if (ok) $display("FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b busy=%b data=%h required 1/0/1/%h",
                                 c, out_valid, in_ready, busy, data_o, STD_PT);
                ok = 1'b0;
            end
        end
        total++; if (!ok) bad++;
        release_out();
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_in_ready: got %b required 1", in_ready); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL bp_busy: got %b required 0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_out_valid: got %b required 0", out_valid); end
    endtask

    task automatic test_ignored_input();
        int lat;
        send(STD_CT);
        repeat (20) @(negedge clk);
        in_valid = 1'b1;
        data_i   = rand128();
        repeat (30) @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        total++; if (lat != LAT - 50) begin bad++; $display("FAIL ign_latency: got %0d required %0d", lat, LAT - 50); end
        total++; if (data_o !== STD_PT) begin bad++; $display("FAIL ign_data: got %h required %h", data_o, STD_PT); end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        send(STD_CT);
        repeat (69) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rmid_in_ready: got %b required 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b required 0", out_valid); end
        total++; if (data_o !== '0)      begin bad++; $display("FAIL rmid_data_o: got %h required 0", data_o); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rmid_busy: got %b required 0", busy); end
        send(STD_CT);
        wait_out(lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL rmid_latency: got %0d required %0d", lat, LAT); end
        total++; if (data_o !== STD_PT) begin bad++; $display("FAIL rmid_data: got %h required %h", data_o, STD_PT); end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [127:0] pa, pb, d1, d2;
        int n, t1, t2;
        logic prev;
        pa = rand128();
        pb = rand128();
        t1 = -1; t2 = -1; d1 = '0; d2 = '0; prev = 1'b0; n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_i    = mdl_encrypt(pa);
        @(posedge clk);
        @(negedge clk);
        data_i = mdl_encrypt(pb);
        while (t2 < 0 && n < 2 * TIMEOUT) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid === 1'b1 && !prev) begin
                if (t1 < 0) begin t1 = n; d1 = data_o; end
                else begin t2 = n; d2 = data_o; end
            end
            prev = (out_valid === 1'b1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (t1 != LAT) begin bad++; $display("FAIL b2b_first_latency: got %0d required %0d", t1, LAT); end
        total++; if (t2 - t1 != 155) begin bad++; $display("FAIL b2b_spacing: got %0d required 155", t2 - t1); end
        total++; if (d1 !== pa) begin bad++; $display("FAIL b2b_data0: got %h required %h", d1, pa); end
        total++; if (d2 !== pb) begin bad++; $display("FAIL b2b_data1: got %h required %h", d2, pb); end
    endtask

    task automatic test_primitives();
        logic [127:0] cin [3];
        logic [127:0] exp [3];
        logic [127:0] p;
        int lat;
        p = rand128();
        cin[0] = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
        exp[0] = mdl_sinv(128'h64a59400000000000000000000000000);
        cin[1] = mdl_lt(128'hb66cd8887d38e8d77765aeea0c9a7efc);
        exp[1] = 128'hffeeddccbbaa99881122334455667700;
        cin[2] = mdl_lt(mdl_s(p));
        exp[2] = p;
        out_ready2 = 1'b1;
        for (int v = 0; v < 3; v++) begin
            in_valid2 = 1'b1;
            data_i2   = cin[v];
            @(posedge clk);
            @(negedge clk);
            in_valid2 = 1'b0;
            lat = 0;
            while (out_valid2 !== 1'b1 && lat < TIMEOUT) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            total++; if (lat != 17) begin bad++; $display("FAIL prim_latency[%0d]: got %0d required 17", v, lat); end
            total++; if (data_o2 !== exp[v]) begin bad++; $display("FAIL prim_data[%0d]: got %h required %h", v, data_o2, exp[v]); end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_i = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; data_i2 = '0;
        expand_keys(MASTER_KEY);
        test_reset();
        test_standard();
        test_random();
        test_backpressure();
        test_ignored_input();
        test_reset_mid();
        test_back_to_back();
        test_primitives();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
